// File: rtl/vx_mem_responder_pkg.sv
// Shared widths and helpers for the memory responder and its response queue.
package vx_mem_responder_pkg;

    // Default widths of the core's memory port.
    localparam int DcacheMemDataWidth    = 512;
    localparam int Xlen                  = 32;
    localparam int L1MemTagWidth         = 8;
    localparam int DcacheMemReqSizeWidth = 6;

    // Credit counter must hold every value 0..queue_size inclusive.
    function automatic int mem_rsp_credit_width(input int queue_size);
        return $clog2(queue_size + 1);
    endfunction

    // Smallest usable pointer width for a circular buffer of 'depth' entries.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_responder_rsp_queue.sv
// Show-ahead response queue: the head entry is visible on pop_data whenever
// the queue is non-empty. Push and pop may occur in the same cycle.
module vx_mem_responder_rsp_queue
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full
);

    localparam int PtrWidth   = ptr_width(SIZE);
    localparam int CountWidth = $clog2(SIZE + 1);

    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(SIZE - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(SIZE);

    logic [DATA_WIDTH-1:0] storage [SIZE];

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;

    logic push_en;
    logic pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign pop_data = storage[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap for non-power-of-two depths.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state register; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset, contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            storage[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side responder: a block RAM behind the core's memory request port.
// Writes update the RAM with byte enables and produce nothing; reads are
// returned as tagged responses after a fixed latency, in accept order.
// Backpressure on the response side reaches the requester only through a
// read-credit counter sized to the response queue, so the queue never fills.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = DcacheMemDataWidth,
    parameter int ADDR_WIDTH     = Xlen,
    parameter int TAG_WIDTH      = L1MemTagWidth,
    parameter int SIZE_WIDTH     = DcacheMemReqSizeWidth,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [SIZE_WIDTH-1:0]   mem_req_size,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,

    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,

    output logic                    busy
);

    localparam int ByteCount   = DATA_WIDTH / 8;
    localparam int Ofs         = $clog2(ByteCount);
    localparam int RamDepth    = 1 << RAM_ADDR_WIDTH;
    // The RAM output register counts as the first of the LATENCY-1 stages.
    localparam int NumStages   = LATENCY - 1;
    localparam int Last        = NumStages - 1;
    localparam int CreditWidth = mem_rsp_credit_width(RSP_QUEUE_SIZE);
    localparam int QueueWidth  = DATA_WIDTH + TAG_WIDTH;

    localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(RSP_QUEUE_SIZE);

    logic [DATA_WIDTH-1:0] ram [RamDepth];

    logic [RAM_ADDR_WIDTH-1:0] line_idx;
    logic                      req_fire;
    logic                      wr_fire;
    logic                      rd_fire;

    logic [NumStages-1:0]                 stg_valid;
    logic [NumStages-1:0][TAG_WIDTH-1:0]  stg_tag;
    logic [NumStages-1:0][DATA_WIDTH-1:0] stg_data;

    logic [CreditWidth-1:0] credits_q, credits_d;

    logic                  q_push;
    logic [QueueWidth-1:0] q_push_data;
    logic                  q_pop;
    logic [QueueWidth-1:0] q_pop_data;
    logic                  q_empty;
    logic                  q_full;

    // Size, address bits outside the line index and the queue full flag are
    // intentionally ignored.
    logic unused_sigs;
    assign unused_sigs = ^{mem_req_size, mem_req_addr, q_full};

    // Upper bits alias modulo RAM size; offset bits select within a line.
    assign line_idx = mem_req_addr[RAM_ADDR_WIDTH+Ofs-1:Ofs];

    // Writes are never stalled; reads need a free credit.
    assign mem_req_ready = !reset && (mem_req_rw || (credits_q != '0));
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign wr_fire       = req_fire && mem_req_rw;
    assign rd_fire       = req_fire && !mem_req_rw;

    assign busy = (credits_q != CreditMax);

    // RAM port plus the data half of the latency pipeline. Left unreset so it
    // maps onto block RAM; reads and writes never share a cycle, and a write
    // is visible to a read accepted on any later edge.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < ByteCount; b++) begin
                if (mem_req_byteen[b]) begin
                    ram[line_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
        for (int i = NumStages - 1; i > 0; i--) begin
            stg_data[i] <= stg_data[i-1];
        end
        if (rd_fire) begin
            stg_data[0] <= ram[line_idx];
        end
    end

    // Valid/tag half of the latency pipeline; always advances, never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_tag   <= '0;
        end else begin
            for (int i = NumStages - 1; i > 0; i--) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_tag[i]   <= stg_tag[i-1];
            end
            stg_valid[0] <= rd_fire;
            stg_tag[0]   <= mem_req_tag;
        end
    end

    assign q_push      = stg_valid[Last];
    assign q_push_data = {stg_tag[Last], stg_data[Last]};
    assign q_pop       = mem_rsp_valid && mem_rsp_ready;

    vx_mem_responder_rsp_queue #(
        .DATA_WIDTH (QueueWidth),
        .SIZE       (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_pop_data),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Credits track reads in the pipeline plus reads waiting in the queue.
    always_comb begin
        credits_d = credits_q;
        if (rd_fire && !q_pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!rd_fire && q_pop) begin
            credits_d = credits_q + 1'b1;
        end
    end

    // Credit counter register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q <= CreditMax;
        end else begin
            credits_q <= credits_d;
        end
    end

    // Response outputs read as zero whenever nothing is being presented.
    assign mem_rsp_valid = !q_empty;
    assign {mem_rsp_tag, mem_rsp_data} = q_empty ? '0 : q_pop_data;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder with default parameters
// (512-bit lines, 8-bit tags, 1024 lines, latency 4, queue/credits 4).
module tb_vx_mem_responder;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int TW = 8;
    localparam int SW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            mem_req_valid = 1'b0;
    logic            mem_req_rw = 1'b0;
    logic [DW/8-1:0] mem_req_byteen = '0;
    logic [SW-1:0]   mem_req_size = '0;
    logic [AW-1:0]   mem_req_addr = '0;
    logic [DW-1:0]   mem_req_data = '0;
    logic [TW-1:0]   mem_req_tag = '0;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic [TW-1:0]   mem_rsp_tag;
    logic            mem_rsp_ready = 1'b0;
    logic            busy;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [DW/8-1:0] AllBytes = '1;

    vx_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_size   (mem_req_size),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                            input logic [DW-1:0] data);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_addr   = addr;
        mem_req_byteen = be;
        mem_req_data   = data;
        #1;
        check("wr_ready", mem_req_ready, 1);
        tick();
        mem_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        #1;
        check("rd_ready", mem_req_ready, 1);
        tick();
        mem_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && !mem_rsp_valid; i++) tick();
        check("rsp_arrived", mem_rsp_valid, 1);
    endtask

    initial begin
        int seen;
        int acc;

        // Reset state.
        mem_req_rw = 1'b1;
        tick(); tick(); tick();
        check("rst_req_ready", mem_req_ready, 0);
        reset = 1'b0;
        mem_req_rw = 1'b0;
        #1;
        check("rst_rsp_valid", mem_rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_data", mem_rsp_data, 0);
        check("rst_rsp_tag", mem_rsp_tag, 0);
        check("rst_rd_ready", mem_req_ready, 1);

        // Single read: line 5 (0x140), tag 3, latency 4.
        do_write(32'h140, AllBytes, fill(8'hA5));
        do_read(32'h140, 8'd3);
        check("rd1_busy_t1", busy, 1);
        check("rd1_valid_t1", mem_rsp_valid, 0);
        tick();
        check("rd1_valid_t2", mem_rsp_valid, 0);
        tick();
        check("rd1_valid_t3", mem_rsp_valid, 0);
        tick();
        check("rd1_valid_t4", mem_rsp_valid, 1);
        check("rd1_data", mem_rsp_data, fill(8'hA5));
        check("rd1_tag", mem_rsp_tag, 3);
        check("rd1_busy_t4", busy, 1);
        tick();
        check("rd1_hold_valid", mem_rsp_valid, 1);
        check("rd1_hold_tag", mem_rsp_tag, 3);
        check("rd1_hold_data", mem_rsp_data, fill(8'hA5));
        mem_rsp_ready = 1'b1;
        tick();
        mem_rsp_ready = 1'b0;
        check("rd1_popped", mem_rsp_valid, 0);
        check("rd1_idle", busy, 0);

        // Partial write then read next cycle.
        do_write(32'h40, AllBytes, fill(8'hCC));
        do_write(32'h40, 64'hF, {{60{8'hFF}}, 32'h11223344});
        check("wr_no_busy", busy, 0);
        check("wr_no_rsp", mem_rsp_valid, 0);
        do_read(32'h40, 8'd7);
        wait_rsp(8);
        check("pw_data", mem_rsp_data, {{60{8'hCC}}, 32'h11223344});
        check("pw_tag", mem_rsp_tag, 7);
        mem_rsp_ready = 1'b1;
        tick();
        mem_rsp_ready = 1'b0;
        check("pw_single_rsp", mem_rsp_valid, 0);

        // Back-to-back reads under backpressure, then simultaneous accept/pop.
        for (int i = 0; i < 6; i++) begin
            do_write(AW'((10 + i) * 64), AllBytes, fill(8'h10 + 8'(i)));
        end
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_req_addr = AW'((10 + i) * 64);
            mem_req_tag  = TW'(i);
            #1;
            check("b2b_ready", mem_req_ready, 1);
            tick();
        end
        mem_req_addr = AW'(14 * 64);
        mem_req_tag  = 8'd4;
        #1;
        check("b2b_stall", mem_req_ready, 0);
        repeat (6) tick();
        check("b2b_still_stall", mem_req_ready, 0);
        check("b2b_head_valid", mem_rsp_valid, 1);
        check("b2b_head_tag", mem_rsp_tag, 0);
        check("b2b_head_data", mem_rsp_data, fill(8'h10));
        mem_rsp_ready = 1'b1;
        #1;
        check("pop_cycle_ready", mem_req_ready, 0);
        tick();
        check("after_pop_ready", mem_req_ready, 1);
        check("b2b_tag1", mem_rsp_tag, 1);
        tick();
        mem_req_addr = AW'(15 * 64);
        mem_req_tag  = 8'd5;
        #1;
        check("b2b_ready5", mem_req_ready, 1);
        check("b2b_tag2", mem_rsp_tag, 2);
        check("b2b_data2", mem_rsp_data, fill(8'h12));
        tick();
        mem_req_valid = 1'b0;
        check("b2b_tag3", mem_rsp_tag, 3);
        tick();
        for (int k = 4; k < 6; k++) begin
            wait_rsp(10);
            check("b2b_tail_tag", mem_rsp_tag, TW'(k));
            check("b2b_tail_data", mem_rsp_data, fill(8'h10 + 8'(k)));
            tick();
        end
        check("b2b_drained", mem_rsp_valid, 0);
        check("b2b_idle", busy, 0);

        // Address alias: 0x10000 wraps onto line 0.
        do_write(32'h0, AllBytes, fill(8'h5A));
        do_write(32'h10000, AllBytes, fill(8'h3C));
        do_read(32'h0, 8'd9);
        wait_rsp(8);
        check("alias_data", mem_rsp_data, fill(8'h3C));
        check("alias_tag", mem_rsp_tag, 9);
        tick();

        // Reset with three reads in flight.
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_req_addr = AW'((10 + i) * 64);
            mem_req_tag  = TW'(20 + i);
            #1;
            check("mid_ready", mem_req_ready, 1);
            tick();
        end
        mem_req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        seen = 0;
        repeat (8) begin
            if (mem_rsp_valid) seen++;
            tick();
        end
        check("mid_no_rsp", seen, 0);
        mem_rsp_ready = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr  = AW'(10 * 64);
        mem_req_tag   = 8'd30;
        acc = 0;
        repeat (6) begin
            #1;
            if (mem_req_ready) acc++;
            tick();
        end
        mem_req_valid = 1'b0;
        check("mid_credits", acc, 4);
        mem_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(10);
            check("mid_drain_tag", mem_rsp_tag, 30);
            tick();
        end
        check("mid_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
